// File: rtl/mult_control.sv
// Sequencer for the add-shift signed multiplier: clears X/A, walks WIDTH
// add/shift iterations driven by the multiplier LSB M, then holds the result.
module mult_control #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Run,
    input  logic          ClearA_LoadB,
    input  logic          M,
    output logic          Ld_B,
    output logic          Clr_XA,
    output logic          Ld_XA,
    output logic          Fn,
    output logic          Shift_En,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Iter
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADD,
        S_SHIFT,
        S_HOLD
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        Ld_B     = 1'b0;
        Clr_XA   = 1'b0;
        Ld_XA    = 1'b0;
        Fn       = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        Iter     = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = S_START;
                end else if (ClearA_LoadB && !Reset) begin
                    // Switch load is suppressed while Reset is held
                    Ld_B   = 1'b1;
                    Clr_XA = 1'b1;
                end
            end
            S_START: begin
                Busy    = 1'b1;
                Clr_XA  = 1'b1;
                cnt_d   = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                Busy    = 1'b1;
                Ld_XA   = M;
                // Sign bit of the multiplier has negative weight
                Fn      = (cnt_q == LAST);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                Busy     = 1'b1;
                Shift_En = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_ADD;
                end
            end
            S_HOLD: begin
                Done = 1'b1;
                if (!Run) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control: directed vector table, corner
// sequences, and randomized traffic against a step-count reference model.
module tb_mult_control;
    localparam int W  = 8;
    localparam int CW = $clog2(W);
    localparam int OW = 7 + CW;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset, Run, ClearA_LoadB, M;
    logic Ld_B, Clr_XA, Ld_XA, Fn, Shift_En, Busy, Done;
    logic [CW-1:0] Iter;
    logic [OW-1:0] obs;

    mult_control #(.WIDTH(W), .CW(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .Ld_B(Ld_B), .Clr_XA(Clr_XA), .Ld_XA(Ld_XA), .Fn(Fn), .Shift_En(Shift_En),
        .Busy(Busy), .Done(Done), .Iter(Iter)
    );

    assign obs = {Ld_B, Clr_XA, Ld_XA, Fn, Shift_En, Busy, Done, Iter};

    int checks = 0;
    int errors = 0;

    // Reference: mt = -1 idle, 0 start, 1..2W alternating add/shift, 2W+1 hold
    int mt = -1;
    int last_iter = 0;

    int n_sh, n_ld, n_fn, n_busy, n_done, n_clr, first_done, idx;

    typedef struct {
        logic          rst, run, clb, m;
        logic [OW-1:0] exp;
    } vec_t;
    vec_t vec[25];

    function automatic logic [OW-1:0] model_out(input logic r, input logic run_i,
                                                 input logic clb_i, input logic m_i);
        logic ldb, clr, ldxa, fn, sh, busy, done;
        int it;
        ldb = 0; clr = 0; ldxa = 0; fn = 0; sh = 0; busy = 0; done = 0;
        it = (mt >= 1 && mt <= 2 * W) ? (mt - 1) / 2 : last_iter;
        if (mt < 0) begin
            if (!run_i && clb_i && !r) begin ldb = 1; clr = 1; end
        end else if (mt == 0) begin
            clr = 1; busy = 1;
        end else if (mt <= 2 * W) begin
            busy = 1;
            if (mt % 2 == 1) begin
                ldxa = m_i;
                fn   = (it == W - 1);
            end else begin
                sh = 1;
            end
        end else begin
            done = 1;
        end
        return {ldb, clr, ldxa, fn, sh, busy, done, CW'(it)};
    endfunction

    task automatic check_v(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic reset_stats();
        n_sh = 0; n_ld = 0; n_fn = 0; n_busy = 0; n_done = 0; n_clr = 0;
        first_done = -1; idx = 0;
    endtask

    task automatic cyc(input logic r, input logic run_i, input logic clb_i, input logic m_i,
                       input bit use_t, input logic [OW-1:0] texp);
        logic [OW-1:0] e;
        Reset = r; Run = run_i; ClearA_LoadB = clb_i; M = m_i;
        @(negedge Clk);
        e = model_out(r, run_i, clb_i, m_i);
        check_v("model", obs, e);
        if (use_t) check_v("table", obs, texp);
        n_sh   += int'(Shift_En);
        n_ld   += int'(Ld_XA);
        n_fn   += int'(Fn);
        n_busy += int'(Busy);
        n_done += int'(Done);
        n_clr  += int'(Clr_XA);
        if (Done && first_done < 0) first_done = idx;
        idx++;
        @(posedge Clk);
        if (r) begin
            mt = -1; last_iter = 0;
        end else begin
            last_iter = int'(e[CW-1:0]);
            if (mt < 0) begin
                if (run_i) mt = 0;
            end else if (mt <= 2 * W) begin
                mt++;
            end else if (!run_i) begin
                mt = -1;
            end
        end
        #1;
    endtask

    task automatic set_v(input int i, input logic r, input logic run_i, input logic clb_i,
                         input logic m_i, input logic [OW-1:0] exp);
        vec[i].rst = r; vec[i].run = run_i; vec[i].clb = clb_i; vec[i].m = m_i; vec[i].exp = exp;
    endtask

    initial begin
        //          rst run clb m    LdB Clr LdXA Fn Sh Busy Done Iter
        set_v( 0, 1, 1, 1, 0, 10'b0_0_0_0_0_0_0_000);
        set_v( 1, 0, 0, 1, 0, 10'b1_1_0_0_0_0_0_000);
        set_v( 2, 0, 0, 0, 0, 10'b0_0_0_0_0_0_0_000);
        set_v( 3, 0, 1, 1, 0, 10'b0_0_0_0_0_0_0_000);
        set_v( 4, 0, 0, 0, 0, 10'b0_1_0_0_0_1_0_000);
        set_v( 5, 0, 0, 0, 0, 10'b0_0_0_0_0_1_0_000);
        set_v( 6, 0, 0, 0, 0, 10'b0_0_0_0_1_1_0_000);
        set_v( 7, 0, 0, 0, 1, 10'b0_0_1_0_0_1_0_001);
        set_v( 8, 0, 0, 0, 0, 10'b0_0_0_0_1_1_0_001);
        set_v( 9, 0, 0, 0, 0, 10'b0_0_0_0_0_1_0_010);
        set_v(10, 0, 0, 0, 0, 10'b0_0_0_0_1_1_0_010);
        set_v(11, 0, 0, 1, 0, 10'b0_0_0_0_0_1_0_011);
        set_v(12, 0, 0, 0, 0, 10'b0_0_0_0_1_1_0_011);
        set_v(13, 0, 0, 0, 1, 10'b0_0_1_0_0_1_0_100);
        set_v(14, 0, 0, 0, 0, 10'b0_0_0_0_1_1_0_100);
        set_v(15, 0, 0, 0, 1, 10'b0_0_1_0_0_1_0_101);
        set_v(16, 0, 0, 0, 0, 10'b0_0_0_0_1_1_0_101);
        set_v(17, 0, 0, 0, 0, 10'b0_0_0_0_0_1_0_110);
        set_v(18, 0, 0, 0, 0, 10'b0_0_0_0_1_1_0_110);
        set_v(19, 0, 0, 0, 1, 10'b0_0_1_1_0_1_0_111);
        set_v(20, 0, 0, 0, 0, 10'b0_0_0_0_1_1_0_111);
        set_v(21, 0, 1, 0, 0, 10'b0_0_0_0_0_0_1_111);
        set_v(22, 0, 0, 1, 0, 10'b0_0_0_0_0_0_1_111);
        set_v(23, 0, 0, 0, 0, 10'b0_0_0_0_0_0_0_111);
        set_v(24, 0, 0, 1, 0, 10'b1_1_0_0_0_0_0_111);

        Reset = 1; Run = 1; ClearA_LoadB = 1; M = 0;
        @(posedge Clk);
        #1;

        reset_stats();
        for (int i = 0; i < 25; i++)
            cyc(vec[i].rst, vec[i].run, vec[i].clb, vec[i].m, 1'b1, vec[i].exp);
        check_int("tbl_shifts", n_sh, W);
        check_int("tbl_ldxa", n_ld, 4);

        // One-cycle Run pulse with M held high
        reset_stats();
        cyc(0, 1, 0, 1, 0, '0);
        repeat (24) cyc(0, 0, 0, 1, 0, '0);
        check_int("m1_shifts", n_sh, W);
        check_int("m1_ldxa", n_ld, W);
        check_int("m1_fn", n_fn, 1);
        check_int("m1_busy", n_busy, 2 * W + 1);
        check_int("m1_done_at", first_done, 2 * W + 2);
        check_int("m1_clr", n_clr, 1);

        // Run held for 40 cycles: single multiply, Done until after release
        reset_stats();
        repeat (40) cyc(0, 1, 1'($urandom), 1'($urandom), 0, '0);
        check_int("hold_shifts", n_sh, W);
        check_int("hold_clr", n_clr, 1);
        check_int("hold_done", n_done, 40 - (2 * W + 2));
        cyc(0, 0, 0, 0, 0, '0);
        check_int("rel_done", n_done, 40 - (2 * W + 1));
        cyc(0, 0, 0, 0, 0, '0);
        check_int("rel_idle", int'({Busy, Done}), 0);
        reset_stats();
        cyc(0, 1, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 0, 10'b0_1_0_0_0_1_0_111);
        repeat (20) cyc(0, 0, 0, 1'($urandom), 0, '0);
        check_int("rerun_busy", n_busy, 2 * W + 1);
        check_int("rerun_done_at", first_done, 2 * W + 2);

        // Reset mid-multiply aborts cleanly
        reset_stats();
        cyc(0, 1, 0, 1, 0, '0);
        repeat (5) cyc(0, 0, 0, 1, 0, '0);
        cyc(1, 0, 1, 1, 0, '0);
        reset_stats();
        cyc(0, 0, 0, 1, 0, 10'b0_0_0_0_0_0_0_000);
        repeat (20) cyc(0, 0, 0, 1, 0, '0);
        check_int("abort_shifts", n_sh, 0);
        check_int("abort_ldxa", n_ld, 0);
        check_int("abort_done", n_done, 0);
        check_int("abort_busy", n_busy, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom), 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/mult_control.md
# mult_control

Sequencing controller for the add-shift multiplier datapath. It sits directly upstream of the 8-bit shift registers (A, B) and the 1-bit sign register (X), and drives their Load, Shift_En and Reset-style clear controls. It consumes B's Shift_Out (the current multiplier bit M). Each Run request produces exactly one WIDTH-iteration signed multiply: add on M=1, subtract on the final iteration, then shift.

## Interface
- WIDTH, 8, number of add/shift iterations (multiplier width); WIDTH ≥ 2
- CW, $clog2(WIDTH), iteration counter width
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high; forces IDLE, counter 0
- Run  input  1  synchronized level request to start a multiply
- ClearA_LoadB  input  1  synchronized level; in IDLE, loads B from switches and clears X/A
- M  input  1  current multiplier LSB (B register Shift_Out)
- Ld_B  output  1  load B register from switch input
- Clr_XA  output  1  clear X and A registers (drives their Reset input)
- Ld_XA  output  1  load adder result into X and A
- Fn  output  1  adder function: 0 = add, 1 = subtract
- Shift_En  output  1  shift X→A→B right one bit
- Busy  output  1  multiply in progress
- Done  output  1  multiply complete, result held
- Iter  output  CW  current iteration index (debug)

## Operation
- State register plus CW-bit counter. Outputs are combinational from state, counter and inputs.
- States: IDLE, START, ADD, SHIFT, HOLD.
- IDLE:
  - Run=1 → START. Ld_B=0 and Clr_XA=0 that cycle; Run has priority over ClearA_LoadB.
  - Run=0 and ClearA_LoadB=1 → Ld_B=1, Clr_XA=1; stay in IDLE.
  - Otherwise all outputs 0.
- START: Clr_XA=1; counter ← 0; → ADD.
- ADD:
  - Ld_XA = M.
  - Fn = 1 when Iter = WIDTH-1, else 0. Fn is driven even when M=0.
  - → SHIFT.
- SHIFT:
  - Shift_En=1.
  - If Iter = WIDTH-1 → HOLD, counter unchanged.
  - Else counter +1, → ADD.
- HOLD:
  - Done=1; datapath outputs 0; result registers untouched.
  - Run=0 → IDLE. Run=1 → stay (no retrigger while Run is held).
  - ClearA_LoadB ignored.
- ClearA_LoadB is ignored in START, ADD, SHIFT and HOLD.
- Busy=1 in START/ADD/SHIFT; 0 in IDLE/HOLD.
- Ld_XA and Shift_En are never asserted in the same cycle. Clr_XA is never asserted together with Ld_XA or Shift_En.
- Iter reads the counter in every state. The counter wraps only through START reset and never overflows.

## Timing
- Reset high at edge → next cycle: state IDLE, Iter=0, Busy=0, Done=0, Ld_XA=0, Shift_En=0, Fn=0.
  - While Reset is high, Ld_B and Clr_XA from IDLE are gated to 0.
  - Reset wins over every other input and over any state, including mid-multiply.
  - An aborted multiply leaves partial datapath contents; no further Shift_En/Ld_XA is issued.
- Run sampled high in IDLE at edge k:
  - START during cycle k+1.
  - ADD/SHIFT pairs occupy cycles k+2 … k+2WIDTH+1.
  - HOLD from cycle k+2WIDTH+2.
  - Busy for 2WIDTH+1 cycles (17 for WIDTH=8).
- M is sampled combinationally during each ADD cycle. M reflects the B LSB after the previous SHIFT edge.
- Exactly WIDTH Shift_En pulses per multiply. Ld_XA pulses equal the number of 1s among the M values seen in ADD cycles.
- Done rises the cycle after the last SHIFT. It falls the cycle after Run is sampled low.

## Test plan
- Reset: assert Reset 2 cycles with Run=1 and ClearA_LoadB=1 → all outputs 0 during and after; state IDLE, Iter=0.
- ClearA_LoadB=1 for 1 cycle in IDLE, Run=0 → Ld_B=1 and Clr_XA=1 for exactly that cycle; no Shift_En.
- Run pulse (1 cycle), M held 1 → Clr_XA at k+1; 8 Ld_XA pulses, Fn=1 only on the 8th (Iter=7); 8 Shift_En pulses; Busy 17 cycles; Done at k+18.
- Run pulse, M pattern 0,1,0,0,1,1,0,1 per ADD → Ld_XA in iterations 1,4,5,7 only; Fn=1 in ADD at Iter=7 regardless; 8 Shift_En.
- Run held high 40 cycles then released → one multiply only; Done high until the cycle after release; IDLE; second Run pulse starts a new 17-cycle sequence with Clr_XA first.
- Run pulse, then Reset at cycle k+6 → next cycle IDLE, Busy=0, Iter=0; no Shift_En/Ld_XA after the reset edge; Done never asserts.
